// File: rtl/pc_fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the PC register and instruction memory.
// Latency: wires only. Backpressure: imem_ready from memory; stall from the pipeline.
// Signals: pc/stall/redirect inputs and imem_ready come into the sequencer;
// nextPC/enable drive the PC register; imem_req/imem_addr/fetch_done/timeout go out.
interface pc_fetch_sequencer_if;
    logic [31:0] pc;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        imem_ready;
    logic [31:0] nextPC;
    logic        enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fetch_done;
    logic        timeout;

    // Sequencer side.
    modport master (
        input  pc, stall, branch_taken, branch_target, jump, jump_target, trap, imem_ready,
        output nextPC, enable, imem_req, imem_addr, fetch_done, timeout
    );

    // Environment side (PC register, pipeline control, instruction memory).
    modport slave (
        output pc, stall, branch_taken, branch_target, jump, jump_target, trap, imem_ready,
        input  nextPC, enable, imem_req, imem_addr, fetch_done, timeout
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Sequences the external PC register through instruction fetch (INIT/FETCH/WAIT/HALT).
// Latency: same-cycle request/ready handshake; PC loads on the next edge, one fetch per cycle at full rate.
// Backpressure: stall blocks a new request; imem_ready low holds the request in WAIT until MAX_WAIT, then sticky timeout.
// Ports: clk, reset (sync, active-high), bus (pc_fetch_sequencer_if.master).
// Optional feature: define SEQ_TRAP_EN to make trap the top-priority redirect to TRAP_VECTOR.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          MAX_WAIT     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_sequencer_if.master bus
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]  state;
    logic        pend_vld;
    logic [31:0] pend_tgt;
    logic [7:0]  wait_cnt;
    logic        timeout_q;

    logic        redir_vld;
    logic [31:0] redir_tgt;
    logic        accept;
    logic [31:0] sel_pc;

    // Live redirect winner; later assignments override earlier ones, so the
    // highest priority source is written last.
    always_comb begin
        redir_vld = 1'b0;
        redir_tgt = '0;
        if (bus.branch_taken) begin
            redir_vld = 1'b1;
            redir_tgt = bus.branch_target;
        end
        if (bus.jump) begin
            redir_vld = 1'b1;
            redir_tgt = bus.jump_target;
        end
`ifdef SEQ_TRAP_EN
        if (bus.trap) begin
            redir_vld = 1'b1;
            redir_tgt = TRAP_VECTOR;
        end
`endif
        redir_tgt = {redir_tgt[31:2], 2'b00};
    end

`ifndef SEQ_TRAP_EN
    // Trap input and vector are intentionally dead in this build.
    logic unused_trap;
    assign unused_trap = &{1'b0, bus.trap, TRAP_VECTOR};
`endif

    // Accept target: live redirect, then pending redirect, then sequential (wraps).
    always_comb begin
        sel_pc = bus.pc + 32'd4;
        if (redir_vld) begin
            sel_pc = redir_tgt;
        end else if (pend_vld) begin
            sel_pc = pend_tgt;
        end
        sel_pc = {sel_pc[31:2], 2'b00};
    end

    always_comb begin
        accept         = 1'b0;
        bus.enable     = 1'b0;
        bus.imem_req   = 1'b0;
        bus.fetch_done = 1'b0;
        bus.nextPC     = RESET_VECTOR;
        if (!reset) begin
            case (state)
                ST_INIT: begin
                    bus.enable = 1'b1;
                end
                ST_FETCH: begin
                    bus.imem_req = ~bus.stall;
                    bus.nextPC   = sel_pc;
                    accept       = ~bus.stall & bus.imem_ready;
                end
                ST_WAIT: begin
                    // Request is outstanding, so stall cannot withdraw it.
                    bus.imem_req = 1'b1;
                    bus.nextPC   = sel_pc;
                    accept       = bus.imem_ready;
                end
                default: begin
                end
            endcase
            if (accept) begin
                bus.enable     = 1'b1;
                bus.fetch_done = 1'b1;
            end
        end
    end

    assign bus.imem_addr = bus.pc;
    assign bus.timeout   = timeout_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            pend_vld  <= 1'b0;
            pend_tgt  <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!bus.stall && !bus.imem_ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_ready) begin
                        state <= ST_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        // This cycle is the MAX_WAIT-th unanswered WAIT cycle.
                        if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                            state     <= ST_HALT;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase

            // Pending redirect: latched on non-accept cycles, consumed on accept.
            if (state != ST_HALT) begin
                if (accept) begin
                    pend_vld <= 1'b0;
                end else if (redir_vld) begin
                    pend_vld <= 1'b1;
                    pend_tgt <= redir_tgt;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: directed scenarios plus random traffic against a reference model.
// Latency: checks combinational outputs each cycle at the falling edge.
// Backpressure: drives stall and imem_ready both directed and randomly.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          MW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV),
        .MAX_WAIT    (MW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // PC register owned by the bench, with a force path for the wrap test.
    logic [31:0] pc_q         = 32'hA5A5_0000;
    logic        pc_force_en  = 1'b0;
    logic [31:0] pc_force_val = 32'h0;
    always_ff @(posedge clk) begin
        if (pc_force_en)     pc_q <= pc_force_val;
        else if (bus.enable) pc_q <= bus.nextPC;
    end
    assign bus.pc = pc_q;

    int total = 0;
    int bad   = 0;

    // Reference model: intent-level view of the fetch process.
    bit          m_init    = 1'b0;   // next live cycle is the reset-vector load
    bit          m_out     = 1'b0;   // a request is outstanding with memory
    bit          m_halt    = 1'b0;
    bit          m_timeout = 1'b0;
    int          m_waits   = 0;      // unanswered cycles of the outstanding request
    logic [31:0] m_pend[$];          // at most one pending redirect
    logic [31:0] m_pc      = 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit redir(output logic [31:0] t);
        t = 32'h0;
`ifdef SEQ_TRAP_EN
        if (bus.trap) begin
            t = TV;
            return 1'b1;
        end
`endif
        if (bus.jump) begin
            t = bus.jump_target & ~32'h3;
            return 1'b1;
        end
        if (bus.branch_taken) begin
            t = bus.branch_target & ~32'h3;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle: check outputs against the model, advance the model.
    task automatic step();
        logic        e_en, e_req, e_done, e_to;
        logic [31:0] e_npc, rt;
        bit          rv, acc;
        @(negedge clk);
        e_en = 1'b0; e_req = 1'b0; e_done = 1'b0; e_npc = RV; acc = 1'b0;
        rv   = redir(rt);
        e_to = m_timeout && !reset;
        if (!reset && !m_halt) begin
            if (m_init) begin
                e_en = 1'b1;
            end else begin
                e_req = m_out || !bus.stall;
                acc   = e_req && bus.imem_ready;
                if (acc) begin
                    e_en   = 1'b1;
                    e_done = 1'b1;
                    e_npc  = rv ? rt : (m_pend.size() != 0 ? m_pend[0] : m_pc + 32'd4);
                end
            end
        end
        chk("enable",     32'(bus.enable),     32'(e_en));
        chk("imem_req",   32'(bus.imem_req),   32'(e_req));
        chk("fetch_done", 32'(bus.fetch_done), 32'(e_done));
        chk("timeout",    32'(bus.timeout),    32'(e_to));
        chk("imem_addr",  bus.imem_addr,       m_pc);
        if (e_en || reset) chk("nextPC", bus.nextPC, e_npc);

        if (reset) begin
            m_init = 1'b1; m_out = 1'b0; m_waits = 0;
            m_halt = 1'b0; m_timeout = 1'b0;
            m_pend.delete();
        end else if (!m_halt) begin
            if (acc) m_pend.delete();
            else if (rv) begin
                m_pend.delete();
                m_pend.push_back(rt);
            end
            if (m_init) m_init = 1'b0;
            else if (acc) m_out = 1'b0;
            else if (e_req) begin
                if (m_out) begin
                    m_waits++;
                    if (m_waits == MW) begin
                        m_halt    = 1'b1;
                        m_timeout = 1'b1;
                    end
                end else begin
                    m_out   = 1'b1;
                    m_waits = 0;
                end
            end
        end
        if (e_en) m_pc = e_npc;
        if (pc_force_en) m_pc = pc_force_val;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.trap = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        bus.branch_target = 32'h0; bus.jump_target = 32'h0;
        bus.imem_ready = 1'b1;

        // Reset then sequential fetch.
        step();
        reset = 1'b0;
        step();
        chk("t1_init_pc", pc_q, RV);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t1_seq_pc", pc_q, 32'(4 * k));
        end

        // Redirect during WAIT at pc 0x10.
        bus.imem_ready = 1'b0;
        step();
        bus.jump = 1'b1; bus.jump_target = 32'h200;
        step();
        chk("t2_req_held", 32'(bus.imem_req), 32'h1);
        bus.jump = 1'b0;
        step();
        chk("t2_addr_stable", bus.imem_addr, 32'h10);
        bus.imem_ready = 1'b1;
        step();
        chk("t2_pc_redirect", pc_q, 32'h200);

        // Stall, then simultaneous branch and jump, then unaligned branch.
        bus.stall = 1'b1;
        step();
        step();
        chk("t3_pc_frozen", pc_q, 32'h200);
        chk("t3_req_low", 32'(bus.imem_req), 32'h0);
        chk("t3_en_low", 32'(bus.enable), 32'h0);
        bus.stall = 1'b0;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
        bus.jump = 1'b1; bus.jump_target = 32'h80;
        step();
        chk("t3_jump_wins", pc_q, 32'h80);
        bus.jump = 1'b0; bus.branch_target = 32'h43;
        step();
        chk("t3_align", pc_q, 32'h40);
        quiet();

        // Redirect during stall is held and consumed once.
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h500;
        step();
        bus.branch_taken = 1'b0;
        step();
        bus.stall = 1'b0;
        step();
        chk("pend_used", pc_q, 32'h500);
        step();
        chk("pend_cleared", pc_q, 32'h504);

        // Wrap-around.
        bus.stall = 1'b1; pc_force_en = 1'b1; pc_force_val = 32'hFFFF_FFFC;
        step();
        pc_force_en = 1'b0;
        chk("t4_forced", pc_q, 32'hFFFF_FFFC);
        bus.stall = 1'b0;
        step();
        chk("t4_wrap", pc_q, 32'h0);

        // Trap together with jump on accept.
        bus.trap = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h300;
        step();
`ifdef SEQ_TRAP_EN
        chk("t6_trap", pc_q, TV);
`else
        chk("t6_trap", pc_q, 32'h300);
`endif
        quiet();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset             = ($urandom_range(99) < 2);
            bus.stall         = ($urandom_range(3) == 0);
            bus.imem_ready    = ($urandom_range(9) < 6);
            bus.branch_taken  = ($urandom_range(9) == 0);
            bus.jump          = ($urandom_range(9) == 0);
            bus.trap          = ($urandom_range(11) == 0);
            bus.branch_target = $urandom();
            bus.jump_target   = $urandom();
            step();
        end
        quiet();

        // Timeout after MAX_WAIT unanswered WAIT cycles, then recovery.
        reset = 1'b1;
        step();
        reset = 1'b0; bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        step();
        for (int w = 1; w < MW; w++) step();
        chk("t5_no_timeout_yet", 32'(bus.timeout), 32'h0);
        step();
        chk("t5_timeout", 32'(bus.timeout), 32'h1);
        chk("t5_en_low", 32'(bus.enable), 32'h0);
        chk("t5_req_low", 32'(bus.imem_req), 32'h0);
        bus.imem_ready = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h700;
        step();
        chk("t5_halt_sticky", 32'(bus.timeout), 32'h1);
        chk("t5_halt_pc", pc_q, RV);
        quiet();
        reset = 1'b1;
        step();
        chk("t5_reset_clears", 32'(bus.timeout), 32'h0);
        reset = 1'b0;
        step();
        chk("t5_restart_pc", pc_q, RV);
        step();
        chk("t5_restart_seq", pc_q, RV + 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

- Controller that sequences the program counter register (`ProgramCounter`, ports `clk/reset/nextPC/enable/pc`) through instruction fetch.
- Each cycle it selects `nextPC` (reset vector, sequential, branch, jump or trap), gates the PC's `enable`, and runs a request/ready handshake with instruction memory.
- It holds redirects that arrive mid-fetch and raises a sticky timeout when memory never answers.

## Interface

**Parameters**
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect target on trap (only when `SEQ_TRAP_EN` is defined).
- `MAX_WAIT`, default 8: WAIT cycles allowed before timeout; legal range 1..255.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: current PC, driven by the PC register's output.
- `stall` in 1: blocks issue of a new fetch.
- `branch_taken` in 1 / `branch_target` in 32: conditional redirect.
- `jump` in 1 / `jump_target` in 32: unconditional redirect.
- `trap` in 1: exception redirect to `TRAP_VECTOR`.
- `imem_ready` in 1: instruction memory accepts or returns the request this cycle.
- `nextPC` out 32: value the PC register loads.
- `enable` out 1: PC register load enable.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equals `pc`.
- `fetch_done` out 1: one-cycle pulse on each accepted fetch.
- `timeout` out 1: sticky, memory never answered.

## Operation

**States:** INIT, FETCH, WAIT, HALT.

- **INIT**
  - Drives `enable=1` and `nextPC=RESET_VECTOR` for one cycle, then moves to FETCH.
  - `imem_req=0`.
- **FETCH**
  - If `stall=1`: `imem_req=0`, `enable=0`, stay in FETCH.
  - Otherwise `imem_req=1`.
  - With `imem_ready=1` in the same cycle this is an **accept**; stay in FETCH.
  - Otherwise go to WAIT and clear the wait counter.
- **WAIT**
  - `imem_req` is held at 1 and `imem_addr` stays stable; `stall` is ignored because the request is outstanding.
  - `imem_ready=1` gives an accept; go to FETCH.
  - Otherwise the counter increments; when it reaches `MAX_WAIT`, go to HALT and set `timeout=1`.
- **HALT**
  - `enable=0`, `imem_req=0`, `fetch_done=0`.
  - Only `reset` exits this state.

**Accept cycle:** `enable=1`, `fetch_done=1`, and `nextPC` is selected by priority:
1. trap
2. jump
3. branch_taken
4. pending redirect
5. `pc+4`

**Redirect rules**
- A redirect seen in a non-accept cycle (FETCH with stall or no ready, WAIT, INIT) is latched into a pending register.
  - The target latched is that cycle's priority winner.
  - A newer redirect overwrites an older pending one.
- A pending redirect is consumed and cleared on the next accept.
- A live redirect in the accept cycle beats pending and also clears it.
- In HALT, redirects are ignored.

**Arithmetic**
- `pc+4` is 32-bit and wraps: 32'hFFFF_FFFC becomes 32'h0000_0000.
- All selected targets have bits [1:0] forced to 00.

## Timing

- `enable`, `nextPC`, `imem_req`, `imem_addr` and `fetch_done` are combinational from state, pending register and current inputs. This is a same-cycle handshake.
- The PC register updates on the following `clk` edge.
- Sequential fetch with `imem_ready` tied high gives one instruction per cycle.
- Each WAIT cycle adds one cycle of latency.
- Reset values (while `reset=1` and on the cycle after):
  - state INIT, pending cleared, wait counter 0, `timeout=0`.
  - During `reset`: `enable=0`, `imem_req=0`, `fetch_done=0`, `nextPC=RESET_VECTOR`.
- Reset asserted mid-WAIT abandons the outstanding request with no `fetch_done`.

## Configuration

- Macro `SEQ_TRAP_EN`.
- **Defined:** `trap` is the top-priority redirect to `TRAP_VECTOR`, including latching as pending.
- **Undefined:** `trap` is ignored, `TRAP_VECTOR` is unused, and the priority is jump > branch > pending > `pc+4`.

## Test plan

1. **Reset then sequential fetch:** `reset` for 1 cycle, `imem_ready=1` -> pc sequence 0x0, 0x4, 0x8, 0xC with `fetch_done` high every cycle.
2. **Redirect during WAIT:**
   - Stimulus: at pc=0x10, `imem_ready=0` for 3 cycles; `jump=1` with `jump_target=0x200` pulsed in WAIT; then ready.
   - Response: `imem_addr` stays 0x10 throughout, and the next pc is 0x200.
3. **Stall plus simultaneous redirects:**
   - `stall=1` for 2 cycles -> `imem_req=0`, `enable=0`, pc frozen.
   - Same-cycle `branch_taken` (0x40) and `jump` (0x80) -> pc becomes 0x80.
   - Branch target 0x43 -> loaded as 0x40.
4. **Wrap-around:** force pc to 0xFFFF_FFFC, accept -> `nextPC=0x0000_0000`.
5. **Timeout:**
   - `imem_ready=0` held with `MAX_WAIT=8` -> `timeout=1` after 8 WAIT cycles; `enable=0` and `imem_req=0` thereafter.
   - `reset` -> `timeout=0` and fetch restarts at `RESET_VECTOR`.
6. **Trap (`SEQ_TRAP_EN` defined):** `trap=1` together with `jump=1` on accept -> pc=0x100. Without the macro the same stimulus gives pc=`jump_target`.
